// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between fetch_unit (master) and the
// instruction memory (slave). One outstanding request at a time.
interface fetch_unit_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit with a one-entry buffer feeding IF/ID.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          redirect_valid,
  input  logic [63:0]   redirect_pc,
  fetch_unit_if.master  imem,
  output logic [31:0]   instruction,
  output logic [63:0]   A,
  output logic          flush
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   fetch_count,
  output logic [31:0]   stall_count
`endif
);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDiscard
  } state_e;

  state_e      state_q;
  logic [63:0] pc_fetch_q;
  logic [31:0] instr_q;
  logic [63:0] pc_q;
  logic        buf_valid_q;

  logic        issue;
  logic        load;

  // Fetch targets are word aligned; the low redirect bits are deliberately dropped.
  logic        unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // A full buffer may only be overwritten if the consumer takes it this cycle.
  assign issue = (state_q == StIdle) && reset && !redirect_valid &&
                 (!buf_valid_q || !stall);
  assign load  = (state_q == StWait) && imem.imem_rvalid && !redirect_valid;

  always_comb begin
    imem.imem_req  = issue;
    imem.imem_addr = pc_fetch_q;
    instruction    = '0;
    A              = '0;
    if (reset && buf_valid_q) begin
      instruction = instr_q;
      A           = pc_q;
    end
    flush = redirect_valid;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      pc_fetch_q  <= RESET_PC;
      instr_q     <= '0;
      pc_q        <= '0;
      buf_valid_q <= 1'b0;
    end else begin
      if (redirect_valid) begin
        pc_fetch_q  <= {redirect_pc[63:2], 2'b00};
        buf_valid_q <= 1'b0;
      end else if (load) begin
        instr_q     <= imem.imem_rdata;
        pc_q        <= pc_fetch_q;
        buf_valid_q <= 1'b1;
        pc_fetch_q  <= pc_fetch_q + 64'd4;
      end else if (!stall) begin
        buf_valid_q <= 1'b0;
      end

      // A response always retires the outstanding request, kept or not.
      unique case (state_q)
        StIdle: begin
          if (issue) state_q <= StWait;
        end
        StWait: begin
          if (imem.imem_rvalid)    state_q <= StIdle;
          else if (redirect_valid) state_q <= StDiscard;
        end
        StDiscard: begin
          if (imem.imem_rvalid) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q;
  logic [31:0] stall_count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      if (load)                 fetch_count_q <= fetch_count_q + 32'd1;
      if (buf_valid_q && stall) stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`else
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a behavioural instruction memory
// whose latency is adjustable per step.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [31:0] instruction;
  logic [63:0] A;
  logic        flush;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  int          tests;
  int          failed;

  // Memory model state
  int          mem_lat;
  logic        m_busy;
  int          m_cnt;
  logic [63:0] m_addr;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        stray;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC (64'h1000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (bus),
    .instruction    (instruction),
    .A              (A),
    .flush          (flush)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
`endif
  );

`ifndef FETCH_PERF_CNT_EN
  assign fetch_count = '0;
  assign stall_count = '0;
`endif

  // Memory word at address a is a[31:0] - 0xFED, so 0x1000 holds 0x13.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] - 32'h0000_0FED;
  endfunction

  assign bus.imem_rvalid = m_rvalid | stray;
  assign bus.imem_rdata  = stray ? 32'hDEAD_BEEF : m_rdata;

  always @(posedge clk) begin
    m_rvalid <= 1'b0;
    if (!reset) begin
      m_busy <= 1'b0;
    end else if (m_busy) begin
      if (m_cnt <= 1) begin
        m_rvalid <= 1'b1;
        m_rdata  <= mem_word(m_addr);
        m_busy   <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (bus.imem_req) begin
      if (mem_lat <= 1) begin
        m_rvalid <= 1'b1;
        m_rdata  <= mem_word(bus.imem_addr);
      end else begin
        m_busy <= 1'b1;
        m_cnt  <= mem_lat - 1;
        m_addr <= bus.imem_addr;
      end
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    tests = 0;
    failed = 0;
    reset = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    mem_lat = 1;
    stray = 1'b0;
    m_busy = 1'b0;
    m_cnt = 0;
    m_addr = '0;
    m_rvalid = 1'b0;
    m_rdata = '0;

    tick();
    tick();
    #1;
    chk("rst_req", bus.imem_req, 1'b0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_A", A, 64'h0);
    chk("rst_flush", flush, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_fetch_cnt", fetch_count, 32'd0);
    chk("rst_stall_cnt", stall_count, 32'd0);
`endif
    redirect_valid = 1'b1;
    #1;
    chk("rst_flush_follows", flush, 1'b1);
    chk("rst_req_redirect", bus.imem_req, 1'b0);
    redirect_valid = 1'b0;

    // Cycle 1: first request at RESET_PC
    reset = 1'b1;
    #1;
    chk("c1_req", bus.imem_req, 1'b1);
    chk("c1_addr", bus.imem_addr, 64'h1000);
    chk("c1_instr", instruction, 32'h0);
    tick();
    #1;
    chk("c2_req", bus.imem_req, 1'b0);
    chk("c2_instr", instruction, 32'h0);
    tick();
    #1;
    chk("c3_instr", instruction, 32'h13);
    chk("c3_A", A, 64'h1000);
    chk("c3_req", bus.imem_req, 1'b1);
    chk("c3_addr", bus.imem_addr, 64'h1004);

    // Five stalled cycles with a full buffer
    stall = 1'b1;
    #1;
    chk("stall_req0", bus.imem_req, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      chk("stall_instr", instruction, 32'h13);
      chk("stall_A", A, 64'h1000);
      chk("stall_req", bus.imem_req, 1'b0);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("stall_cnt5", stall_count, 32'd5);
    chk("stall_fetch_cnt", fetch_count, 32'd1);
`endif
    stall = 1'b0;
    #1;
    chk("unstall_req", bus.imem_req, 1'b1);
    chk("unstall_addr", bus.imem_addr, 64'h1004);
    tick();
    #1;
    chk("f2_empty_instr", instruction, 32'h0);
    chk("f2_empty_A", A, 64'h0);
    chk("f2_wait_req", bus.imem_req, 1'b0);
    tick();
    #1;
    chk("f2_instr", instruction, 32'h17);
    chk("f2_A", A, 64'h1004);
    chk("f2_req", bus.imem_req, 1'b1);
    chk("f2_addr", bus.imem_addr, 64'h1008);
`ifdef FETCH_PERF_CNT_EN
    chk("f2_fetch_cnt", fetch_count, 32'd2);
`endif

    // Redirect while waiting on a slow response
    mem_lat = 3;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 64'h2002;
    #1;
    chk("rd_flush", flush, 1'b1);
    chk("rd_req", bus.imem_req, 1'b0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("rd_flush_off", flush, 1'b0);
    chk("rd_discard_req", bus.imem_req, 1'b0);
    chk("rd_discard_instr", instruction, 32'h0);
    tick();
    #1;
    chk("late_instr", instruction, 32'h0);
    chk("late_req", bus.imem_req, 1'b0);
    tick();
    #1;
    chk("rd_next_req", bus.imem_req, 1'b1);
    chk("rd_next_addr", bus.imem_addr, 64'h2000);
    chk("rd_next_instr", instruction, 32'h0);

    // Redirect coincident with rvalid and stall
    mem_lat = 1;
    tick();
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'h3000;
    #1;
    chk("co_flush", flush, 1'b1);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("co_instr", instruction, 32'h0);
    chk("co_A", A, 64'h0);
    chk("co_req", bus.imem_req, 1'b1);
    chk("co_addr", bus.imem_addr, 64'h3000);
`ifdef FETCH_PERF_CNT_EN
    chk("co_fetch_cnt", fetch_count, 32'd2);
`endif

    // PC wrap at the top of the address space
    stall = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk("wr_req_blocked", bus.imem_req, 1'b0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("wr_req", bus.imem_req, 1'b1);
    chk("wr_addr", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    tick();
    #1;
    chk("wr_instr", instruction, 32'hFFFF_F00F);
    chk("wr_A", A, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wr_next_req", bus.imem_req, 1'b1);
    chk("wr_next_addr", bus.imem_addr, 64'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("wr_fetch_cnt", fetch_count, 32'd3);
`endif

    // Reset while a request is outstanding
    mem_lat = 2;
    tick();
    reset = 1'b0;
    #1;
    chk("mr_req", bus.imem_req, 1'b0);
    chk("mr_instr", instruction, 32'h0);
    chk("mr_A", A, 64'h0);
    tick();
    #1;
    chk("mr_held_instr", instruction, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("mr_fetch_cnt", fetch_count, 32'd0);
    chk("mr_stall_cnt", stall_count, 32'd0);
`endif
    reset = 1'b1;
    mem_lat = 1;
    #1;
    chk("mr_fresh_req", bus.imem_req, 1'b1);
    chk("mr_fresh_addr", bus.imem_addr, 64'h1000);
    tick();
    #1;
    chk("mr_no_stale", instruction, 32'h0);
    chk("mr_wait_req", bus.imem_req, 1'b0);
    tick();
    #1;
    chk("mr_instr_new", instruction, 32'h13);
    chk("mr_A_new", A, 64'h1000);
`ifdef FETCH_PERF_CNT_EN
    chk("mr_fetch_cnt1", fetch_count, 32'd1);
`endif

    // Stray response while idle with a stalled full buffer
    stall = 1'b1;
    stray = 1'b1;
    #1;
    chk("idle_req", bus.imem_req, 1'b0);
    tick();
    stray = 1'b0;
    #1;
    chk("stray_instr", instruction, 32'h13);
    chk("stray_A", A, 64'h1000);
`ifdef FETCH_PERF_CNT_EN
    chk("stray_fetch_cnt", fetch_count, 32'd1);
    chk("stray_stall_cnt", stall_count, 32'd1);
`endif
    stall = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
